// File: rtl/div_clk_checker.sv
// div_clk_checker: samples a divided clock as data, measures period and
// high time in clk_in cycles, tracks lock and latches faults.
module div_clk_checker #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int HIGH_MIN   = 1,
  parameter int HIGH_MAX   = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             locked,
  output logic             fault,
  output logic             stuck,
  output logic [CNT_W-1:0] last_period,
  output logic [CNT_W-1:0] last_high,
  output logic [7:0]       err_cnt
);

  localparam int GR_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   EXP_P   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] TO_M2   = CNT_W'(TIMEOUT - 2);
  localparam logic [GR_W-1:0]  GR_LAST = GR_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    FAULT
  } state_t;

  state_t state, state_nx;

  logic             mon_q;
  logic             mon_qd;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] hc;
  logic [GR_W-1:0]  good_run;
  logic [GR_W-1:0]  good_run_nx;
  logic [7:0]       err_nx;
  logic [7:0]       err_inc;
  logic             per_ok;
  logic             high_ok;
  logic             stuck_set;
  logic             good;
  logic             bad;

  assign rise_pulse = mon_q & ~mon_qd;

  // a saturated cyc gives 2^CNT_W here, never a match
  assign per_ok  = ({1'b0, cyc} + 1'b1) == EXP_P;
  assign high_ok = (hc >= HI_MIN) && (hc <= HI_MAX);

  // fires once, on the edge where cyc steps to TIMEOUT-1
  assign stuck_set = ~rise_pulse & (cyc == TO_M2);

  assign good = rise_pulse & per_ok & high_ok;
  assign bad  = (rise_pulse & ~(per_ok & high_ok))
              | stuck_set;

  assign err_inc = (err_cnt == 8'hFF) ? err_cnt
                                      : err_cnt + 8'd1;

  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mon_q  <= 1'b0;
      mon_qd <= 1'b0;
    end else begin
      mon_q  <= mon_clk;
      mon_qd <= mon_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cyc         <= '0;
      hc          <= '0;
      last_period <= '0;
      last_high   <= '0;
    end else if (rise_pulse) begin
      cyc         <= '0;
      hc          <= CNT_W'(1);
      last_high   <= hc;
      last_period <= (cyc == CNT_MAX) ? CNT_MAX
                                      : cyc + 1'b1;
    end else begin
      if (cyc != CNT_MAX)
        cyc <= cyc + 1'b1;
      if (mon_q && (hc != CNT_MAX))
        hc <= hc + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)
      stuck <= 1'b0;
    else if (clr || rise_pulse)
      stuck <= 1'b0;
    else if (stuck_set)
      stuck <= 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      good_run <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      good_run <= good_run_nx;
      err_cnt  <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    good_run_nx = good_run;
    err_nx      = err_cnt;
    unique case (state)
      IDLE: begin
        // first period after start is partial
        if (rise_pulse) begin
          state_nx    = MEASURE;
          good_run_nx = '0;
        end
      end
      MEASURE: begin
        if (good) begin
          good_run_nx = good_run + 1'b1;
          if (good_run == GR_LAST)
            state_nx = LOCKED;
        end else if (bad) begin
          good_run_nx = '0;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_nx = FAULT;
          err_nx   = err_inc;
        end
      end
      FAULT: begin
        if (bad)
          err_nx = err_inc;
      end
      default: state_nx = IDLE;
    endcase
    if (clr) begin
      state_nx    = IDLE;
      good_run_nx = '0;
      err_nx      = '0;
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// tb_div_clk_checker: directed stimulus for div_clk_checker with an
// event-level reference model compared on every clock.
module tb_div_clk_checker;

  localparam int EXP     = 3;
  localparam int HMIN    = 1;
  localparam int HMAX    = 2;
  localparam int LOCK    = 4;
  localparam int TIMEOUT = 8;

  localparam int S_IDLE  = 0;
  localparam int S_MEAS  = 1;
  localparam int S_LOCK  = 2;
  localparam int S_FAULT = 3;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b1;
  logic       mon_clk = 1'b0;
  logic       clr     = 1'b0;
  logic       rise_pulse;
  logic       locked;
  logic       fault;
  logic       stuck;
  logic [7:0] last_period;
  logic [7:0] last_high;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  div_clk_checker dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .mon_clk     (mon_clk),
    .clr         (clr),
    .rise_pulse  (rise_pulse),
    .locked      (locked),
    .fault       (fault),
    .stuck       (stuck),
    .last_period (last_period),
    .last_high   (last_high),
    .err_cnt     (err_cnt)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: one sample of mon_clk per clock, rises found
  // from sample history, periods and high time from timestamps.
  int samp[$];
  int p      = 0;
  int prev_r = 0;
  bit m_rise = 1'b0;
  bit m_stk  = 1'b0;
  int m_st   = S_IDLE;
  int m_run  = 0;
  int m_err  = 0;
  int m_lp   = 0;
  int m_lh   = 0;

  always @(posedge clk_in) begin
    bit good_evt;
    bit bad_evt;
    bit stk_evt;
    int per;
    int hi;
    good_evt = 1'b0;
    bad_evt  = 1'b0;
    stk_evt  = !m_rise && ((p - prev_r) == TIMEOUT);
    if (reset) begin
      m_st   = S_IDLE;
      m_run  = 0;
      m_err  = 0;
      m_lp   = 0;
      m_lh   = 0;
      m_stk  = 1'b0;
      m_rise = 1'b0;
      if (p > 0) samp[p-1] = 0;
      samp.push_back(0);
      prev_r = p - 1;
    end else begin
      if (m_rise) begin
        per = p - 1 - prev_r;
        hi  = 0;
        for (int k = (prev_r < 0) ? 0 : prev_r; k < p - 1; k++)
          hi += samp[k];
        m_lp     = (per > 255) ? 255 : per;
        m_lh     = (hi > 255) ? 255 : hi;
        good_evt = (per == EXP) && (hi >= HMIN) && (hi <= HMAX);
        bad_evt  = !good_evt;
        prev_r   = p - 1;
      end
      if (stk_evt) bad_evt = 1'b1;
      if (clr) begin
        m_st  = S_IDLE;
        m_run = 0;
        m_err = 0;
        m_stk = 1'b0;
      end else begin
        if (m_rise) m_stk = 1'b0;
        else if (stk_evt) m_stk = 1'b1;
        case (m_st)
          S_IDLE: if (m_rise) begin
            m_st  = S_MEAS;
            m_run = 0;
          end
          S_MEAS: begin
            if (good_evt) begin
              m_run++;
              if (m_run == LOCK) m_st = S_LOCK;
            end else if (bad_evt) begin
              m_run = 0;
            end
          end
          S_LOCK: if (bad_evt) begin
            m_st = S_FAULT;
            m_err++;
          end
          default: if (bad_evt && m_err < 255) m_err++;
        endcase
      end
      samp.push_back(int'(mon_clk));
      m_rise = (samp[p] == 1) && (samp[p-1] == 0);
    end
    p++;
    #1;
    check("rise_pulse", rise_pulse, m_rise);
    check("locked", locked, m_st == S_LOCK);
    check("fault", fault, m_st == S_FAULT);
    check("stuck", stuck, m_stk);
    check("last_period", last_period, m_lp);
    check("last_high", last_high, m_lh);
    check("err_cnt", err_cnt, m_err);
  end

  task automatic period(input int n, input int h,
                        input int clr_at = -1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      mon_clk = (i < h);
      clr     = (i == clr_at);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      mon_clk = 1'b0;
      clr     = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk_in);
    clr = 1'b1;
    @(negedge clk_in);
    clr = 1'b0;
  endtask

  initial begin
    @(negedge clk_in);
    check("rst_locked", locked, 0);
    check("rst_err", err_cnt, 0);
    check("rst_period", last_period, 0);
    @(negedge clk_in);
    reset = 1'b0;

    // ideal divide-by-3, lock after the 5th rise
    repeat (4) period(3, 2);
    check("t1_not_yet", locked, 0);
    period(3, 2);
    check("t1_locked", locked, 1);
    check("t1_period", last_period, 3);
    check("t1_high", last_high, 2);
    check("t1_fault", fault, 0);
    period(3, 1);

    // one long period while locked
    period(4, 2);
    period(3, 1);
    check("t2_fault", fault, 1);
    check("t2_locked", locked, 0);
    check("t2_err", err_cnt, 1);
    check("t2_period", last_period, 4);
    repeat (2) period(3, 2);
    check("t2_fault_hold", fault, 1);
    check("t2_err_hold", err_cnt, 1);

    // clr on the same edge as a rise, in FAULT
    period(3, 2, 1);
    check("t5_fault", fault, 0);
    check("t5_err", err_cnt, 0);
    repeat (4) period(3, 1);
    check("t5_not_yet", locked, 0);
    period(3, 2);
    check("t5_relock", locked, 1);

    // stuck low from locked
    idle(6);
    check("t3_pre_stuck", stuck, 0);
    idle(1);
    check("t3_stuck", stuck, 1);
    check("t3_fault", fault, 1);
    check("t3_err", err_cnt, 1);
    idle(8);
    check("t3_err_once", err_cnt, 1);
    period(3, 2);
    check("t3_unstuck", stuck, 0);
    check("t3_fault_hold", fault, 1);
    period(3, 2);

    // bad period while measuring restarts the good run
    do_clr();
    check("t4_clr_err", err_cnt, 0);
    period(3, 2);
    repeat (2) period(3, 1);
    period(2, 1);
    check("t4_three_good", locked, 0);
    period(3, 2);
    repeat (3) period(3, 2);
    check("t4_not_yet", locked, 0);
    period(3, 1);
    check("t4_locked", locked, 1);

    // asynchronous reset mid-cycle while locked
    #2;
    reset = 1'b1;
    #1;
    check("t6_locked", locked, 0);
    check("t6_period", last_period, 0);
    check("t6_err", err_cnt, 0);
    #9;
    reset = 1'b0;
    repeat (4) period(3, 2);
    check("t6_not_yet", locked, 0);
    period(3, 2);
    check("t6_relock", locked, 1);

    repeat (2) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
